// File: rtl/exec_pkg.sv
// Shared definitions for the Ex-stage multiply/divide unit: opcodes, engine
// states and the sign-application helper used when results are finalised.
package exec_pkg;

   // Wide enough for a 2*XLEN product with XLEN up to 64.
   localparam int SIGN_W = 128;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MFHI  = 3'd4,
      MD_MFLO  = 3'd5,
      MD_MTHI  = 3'd6,
      MD_MTLO  = 3'd7
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_t;

   // Two's-complement negation commutes with truncation, so callers zero-extend
   // in and size-cast the result back to their own width.
   function automatic logic [SIGN_W-1:0] apply_sign(input logic [SIGN_W-1:0] mag,
                                                   input logic neg);
      return neg ? -mag : mag;
   endfunction

endpackage

// File: rtl/exec_muldiv_unit_if.sv
// Ex-stage request/response bundle between the pipeline control and the
// multiply/divide unit.
interface exec_muldiv_unit_if #(
   parameter int XLEN    = 32,
   parameter int FWD_SRC = 2
);
   localparam int SW = $clog2(FWD_SRC + 1);

   logic                      valid_in;
   logic [2:0]                op;
   logic [XLEN-1:0]           busA;
   logic [XLEN-1:0]           busB;
   logic [SW-1:0]             fwd_sel_a;
   logic [SW-1:0]             fwd_sel_b;
   logic [FWD_SRC*XLEN-1:0]   fwd_data;
   logic                      flush;
   logic                      stall_out;
   logic                      busy;
   logic [XLEN-1:0]           result;
   logic                      result_valid;

   modport master (
      output valid_in, op, busA, busB, fwd_sel_a, fwd_sel_b, fwd_data, flush,
      input  stall_out, busy, result, result_valid
   );

   modport slave (
      input  valid_in, op, busA, busB, fwd_sel_a, fwd_sel_b, fwd_data, flush,
      output stall_out, busy, result, result_valid
   );

endinterface

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier and restoring radix-2 divider on magnitudes;
// signs are re-applied in FIX and the finished HI/LO pair is offered for one cycle.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for a mul/div issue; operands latched on start
//   MUL     | retiring MUL_BPC multiplier bits per cycle
//   DIV     | producing one quotient bit per cycle
//   FIX     | signs applied; hi_res/lo_res valid for the HI/LO write
module muldiv_core
   import exec_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_BPC = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            start_mul,
   input  logic            start_div,
   input  logic            is_signed,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   output md_state_t       state,
   output logic            fix,
   output logic [XLEN-1:0] hi_res,
   output logic [XLEN-1:0] lo_res
);

   localparam int CNT_W = $clog2(XLEN + 1);
   localparam int PW    = 2 * XLEN;
   localparam int PP_W  = XLEN + MUL_BPC;

   md_state_t         state_nxt;
   logic [PW-1:0]     acc, mul_next, prod;
   logic [PP_W-1:0]   pp;
   logic [PW+MUL_BPC-1:0] mul_sum;
   logic [XLEN-1:0]   mcand, rem, quo, dvsr, dividend;
   logic [XLEN-1:0]   rem_next, quo_next, a_abs, b_abs;
   logic [XLEN:0]     r2, diff;
   logic [CNT_W-1:0]  cnt;
   logic              neg_lo, neg_rem, div0, op_div;

   assign a_abs = (is_signed && opa[XLEN-1]) ? -opa : opa;
   assign b_abs = (is_signed && opb[XLEN-1]) ? -opb : opb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_mul)      state_nxt = ST_MUL;
            else if (start_div) state_nxt = ST_DIV;
         end
         ST_MUL:  if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
         ST_DIV:  if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (flush) state_nxt = ST_IDLE;
   end

   // Low half of acc holds the not-yet-consumed multiplier bits.
   always_comb begin
      pp = '0;
      for (int j = 0; j < MUL_BPC; j++) begin
         if (acc[j]) pp = pp + (PP_W'(mcand) << j);
      end
      mul_sum  = {{MUL_BPC{1'b0}}, acc} + {pp, {XLEN{1'b0}}};
      mul_next = PW'(mul_sum >> MUL_BPC);
   end

   always_comb begin
      r2   = {rem, quo[XLEN-1]};
      diff = r2 - {1'b0, dvsr};
      if (!diff[XLEN]) begin
         rem_next = diff[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_next = r2[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         mcand    <= '0;
         rem      <= '0;
         quo      <= '0;
         dvsr     <= '0;
         dividend <= '0;
         cnt      <= '0;
         neg_lo   <= 1'b0;
         neg_rem  <= 1'b0;
         div0     <= 1'b0;
         op_div   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_mul || start_div) begin
                  acc      <= {{XLEN{1'b0}}, b_abs};
                  mcand    <= a_abs;
                  rem      <= '0;
                  quo      <= a_abs;
                  dvsr     <= b_abs;
                  dividend <= opa;
                  cnt      <= start_mul ? CNT_W'(XLEN / MUL_BPC) : CNT_W'(XLEN);
                  neg_lo   <= is_signed && (opa[XLEN-1] ^ opb[XLEN-1]);
                  neg_rem  <= is_signed && opa[XLEN-1];
                  div0     <= (opb == '0);
                  op_div   <= !start_mul;
               end
            end
            ST_MUL: begin
               acc <= mul_next;
               cnt <= cnt - CNT_W'(1);
            end
            ST_DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Most-negative / -1 needs no special case: |MIN| / 1 already yields MIN, rem 0.
   always_comb begin
      prod   = PW'(apply_sign(SIGN_W'(acc), neg_lo));
      hi_res = prod[PW-1:XLEN];
      lo_res = prod[XLEN-1:0];
      if (op_div) begin
         if (div0) begin
            hi_res = dividend;
            lo_res = '1;
         end else begin
            hi_res = XLEN'(apply_sign(SIGN_W'(rem), neg_rem));
            lo_res = XLEN'(apply_sign(SIGN_W'(quo), neg_lo));
         end
      end
   end

   assign fix = (state == ST_FIX);

endmodule

// File: rtl/exec_muldiv_unit.sv
// Ex-stage multiply/divide unit: operand forwarding, HI/LO registers, MFHI/MFLO
// read path and the pipeline stall, wrapped around the iterative engine.
module exec_muldiv_unit
   import exec_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int FWD_SRC = 2,
   parameter int MUL_BPC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   exec_muldiv_unit_if.slave bus
);

   localparam int SW = $clog2(FWD_SRC + 1);

   md_op_t          op;
   md_state_t       state;
   logic [XLEN-1:0] opa, opb, hi, lo, hi_res, lo_res;
   logic            idle, fix, is_mul, is_div, is_md, rd_hilo, mt_ok;

   assign op = md_op_t'(bus.op);

   // Selects above FWD_SRC match no source and fall back to the register file.
   always_comb begin
      opa = bus.busA;
      opb = bus.busB;
      for (int k = 0; k < FWD_SRC; k++) begin
         if (bus.fwd_sel_a == SW'(k + 1)) opa = bus.fwd_data[k*XLEN +: XLEN];
         if (bus.fwd_sel_b == SW'(k + 1)) opb = bus.fwd_data[k*XLEN +: XLEN];
      end
   end

   assign idle   = (state == ST_IDLE);
   assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
   assign is_div = (op == MD_DIV)  || (op == MD_DIVU);
   assign is_md  = is_mul || is_div;

   muldiv_core #(
      .XLEN    (XLEN),
      .MUL_BPC (MUL_BPC)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .start_mul (bus.valid_in && is_mul),
      .start_div (bus.valid_in && is_div),
      .is_signed ((op == MD_MULT) || (op == MD_DIV)),
      .opa       (opa),
      .opb       (opb),
      .state     (state),
      .fix       (fix),
      .hi_res    (hi_res),
      .lo_res    (lo_res)
   );

   assign bus.busy      = !idle;
   assign bus.stall_out = bus.valid_in && (!idle || is_md);

   assign rd_hilo          = bus.valid_in && !bus.flush && idle &&
                             ((op == MD_MFHI) || (op == MD_MFLO));
   assign bus.result_valid = rd_hilo;
   assign bus.result       = !rd_hilo ? '0 : (op == MD_MFHI) ? hi : lo;

   assign mt_ok = bus.valid_in && !bus.flush && idle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (fix && !bus.flush) begin
         hi <= hi_res;
         lo <= lo_res;
      end else if (mt_ok && op == MD_MTHI) begin
         hi <= opa;
      end else if (mt_ok && op == MD_MTLO) begin
         lo <= opa;
      end
   end

endmodule
